// File: rtl/axis_byte_fifo.sv
// AXI-stream byte FIFO with first-word-fall-through output register.
// Decouples USB bulk bursts from the UART drain; exposes fill level, almost-full and a high-water mark.
module axis_byte_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  max_level,
  input  logic                    clear_max
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [LW-1:0]         level_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  push;
  logic                  pop;
  logic                  load_head;

  // Every word lives in mem; the output register mirrors the entry at rd_ptr.
  // A push landing on the next head slot (FIFO otherwise empty) is bypassed
  // straight into the output register for single-cycle write-to-output latency.
  always_comb begin
    push       = s_axis_tvalid & s_axis_tready;
    pop        = m_axis_tvalid & m_axis_tready;
    rd_ptr_nxt = rd_ptr + AW'(pop);
    level_nxt  = level + LW'(push) - LW'(pop);
    head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? s_axis_tdata : mem[rd_ptr_nxt];
    load_head  = (pop || !m_axis_tvalid) && (level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      almost_full   <= 1'b0;
      max_level     <= '0;
    end else begin
      wr_ptr        <= wr_ptr + AW'(push);
      rd_ptr        <= rd_ptr_nxt;
      level         <= level_nxt;
      s_axis_tready <= (level_nxt < DEPTH_L);
      almost_full   <= (level_nxt >= AFULL_L);
      m_axis_tvalid <= (level_nxt != '0);
      // Output data only moves when the current head is consumed or absent,
      // which keeps tdata stable while the sink stalls.
      if (load_head) m_axis_tdata <= head_nxt;
      if (clear_max)
        max_level <= level_nxt;
      else if (level_nxt > max_level)
        max_level <= level_nxt;
    end
  end

endmodule

// File: doc/axis_byte_fifo.md
Name: axis_byte_fifo

Overview:
- Synchronous AXI-stream byte FIFO that sits between the usb_cdc OUT endpoint (out_data/out_valid/out_ready) and the uart transmit stream (s_axis_*).
- Absorbs USB bulk bursts so that the host packet rate and the 115200-baud drain rate are decoupled.
- First-word-fall-through output.
- Exposes a fill level, an almost-full flag and a sticky high-water mark for debug.

Parameters:
- DATA_WIDTH, 8, width of the tdata path.
- DEPTH, 64, number of entries. Must be a power of two and ≥ 4.
- AFULL_THRESH, 48, level at or above which almost_full is asserted. Legal range 1..DEPTH.

Ports:
- clk  input  1  system clock (48 MHz clk_pll).
- rst  input  1  reset. Asynchronous, active-high.
- s_axis_tdata  input  DATA_WIDTH  write data from upstream (usb_cdc out_data).
- s_axis_tvalid  input  1  write valid.
- s_axis_tready  output  1  FIFO can accept a word.
- m_axis_tdata  output  DATA_WIDTH  head-of-FIFO data (to uart s_axis_tdata).
- m_axis_tvalid  output  1  head word valid.
- m_axis_tready  input  1  downstream accepts head word.
- level  output  $clog2(DEPTH)+1  current stored-word count, 0..DEPTH.
- almost_full  output  1  level ≥ AFULL_THRESH.
- max_level  output  $clog2(DEPTH)+1  sticky highest level reached since reset or clear.
- clear_max  input  1  synchronous clear of max_level.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, level=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, almost_full=0, max_level=0.
- s_axis_tready is registered. It rises on the first clk edge after rst deasserts.
- Push: occurs when s_axis_tvalid & s_axis_tready at a clk edge. Data is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: occurs when m_axis_tvalid & m_axis_tready at a clk edge. rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- s_axis_tready (registered) is 1 iff the next-state level < DEPTH.
  - No combinational path from m_axis_tready to s_axis_tready.
  - Consequence: when full, a pop in cycle N frees space and tready returns in cycle N+1.
- m_axis_tvalid / m_axis_tdata are driven from an output register (FWFT):
  - A push into an empty FIFO at edge N gives m_axis_tvalid=1 with that data after edge N+1 at the latest. Write-to-output latency is ≤ 2 cycles.
  - While valid and not popped, m_axis_tdata and m_axis_tvalid must hold stable (AXI rule).
  - On pop with further words stored, the next word appears immediately after the same edge, with no bubble: sustained 1 word/clk throughput when both sides are ready.
  - On pop of the last word, m_axis_tvalid drops after that edge.
- level counts every word held, including the one in the output register. Empty ⇔ level=0. Full ⇔ level=DEPTH.
- Simultaneous push and pop when level=1: the output register reloads with the pushed word, so m_axis_tvalid stays 1 (1-cycle latency holds only if the bypass is implemented; ≤2 cycles is mandatory).
- Simultaneous push and pop at full: cannot occur, because tready=0.
- almost_full is registered and derived from next-state level.
- max_level: each cycle, max_level ← max(max_level, next level). clear_max=1 sets it to the next level, and clear has priority.
- Reset mid-operation: all stored data is discarded and outputs return to their reset values immediately, asynchronously. Upstream must treat tready=0 as back-pressure.
- m_axis_tvalid must never assert while level=0.

Test Plan:
- Reset then 5 single pushes 0x11..0x15 with m_axis_tready=0 → level=5; m_axis_tdata=0x11, tvalid=1; s_axis_tready=1.
- Continue pushing 0x00..0x3A with m_ready=0 until full → level=64, s_axis_tready=0 on the edge after the 64th push; almost_full=1 from level 48; max_level=64.
- Full FIFO, raise m_ready for 1 cycle → one word popped; level=63; s_axis_tready=1 one cycle later; output order preserved.
- Both sides streaming continuously for 200 words, with pointer wrap ×3 → output equals input sequence, no gaps after the first word; level stays ≤2.
- Random tvalid/tready (50%) for 10000 words with scoreboard → zero mismatches, level never >64 or <0, tdata stable while tvalid & !tready.
- Assert rst mid-burst at level=20 → immediately level=0, tvalid=0, tready=0; after release, first pushed word 0xA5 appears at the output within 2 cycles; clear_max pulse → max_level equals the current level.
